// File: rtl/csr_pkg.sv
// rtl/csr_pkg.sv - shared CSR bus enums and register map
package csr_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_TIMEOUT = 2'b01,
    ST_ILLEGAL = 2'b10
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_POLL_RD,
    S_POLL_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0]  CSR_CTRL     = 8'h00;
  localparam logic [7:0]  CSR_STATUS   = 8'h04;
  localparam logic [7:0]  CSR_CFG      = 8'h08;
  localparam logic [7:0]  CSR_ERROR    = 8'h0C;
  localparam logic [7:0]  CSR_ID       = 8'h10;
  localparam logic [31:0] CSR_ID_RESET = 32'h1234_ABCD;

endpackage

// File: rtl/csr_initiator.sv
// rtl/csr_initiator.sv - CSR bus master executing write/read/poll commands
module csr_initiator import csr_pkg::*; #(
  parameter int POLL_GAP = 4,
  parameter int TMO_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [7:0]       cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [31:0]      cmd_mask,
  input  logic [TMO_W-1:0] cmd_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [1:0]       rsp_status,
  output logic [TMO_W-1:0] rsp_attempts,
  output logic             csr_wr_en,
  output logic             csr_rd_en,
  output logic [7:0]       csr_addr,
  output logic [31:0]      csr_wr_data,
  input  logic [31:0]      csr_rd_data
);

  localparam int GAP_W = $clog2(POLL_GAP + 1);

  state_e             state_q, state_d;
  logic [31:0]        exp_q, exp_d, mask_q, mask_d;
  logic [TMO_W-1:0]   limit_q, limit_d, att_q, att_d, att_inc;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               wr_en_d, rd_en_d, valid_d, match;
  logic [7:0]         addr_d;
  logic [31:0]        wdata_d, rdata_d;
  logic [1:0]         status_d;
  logic [TMO_W-1:0]   attempts_d;

  assign cmd_ready = (state_q == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      exp_q        <= '0;
      mask_q       <= '0;
      limit_q      <= '0;
      att_q        <= '0;
      gap_q        <= '0;
      csr_wr_en    <= 1'b0;
      csr_rd_en    <= 1'b0;
      csr_addr     <= '0;
      csr_wr_data  <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_status   <= ST_OK;
      rsp_attempts <= '0;
    end else begin
      state_q      <= state_d;
      exp_q        <= exp_d;
      mask_q       <= mask_d;
      limit_q      <= limit_d;
      att_q        <= att_d;
      gap_q        <= gap_d;
      csr_wr_en    <= wr_en_d;
      csr_rd_en    <= rd_en_d;
      csr_addr     <= addr_d;
      csr_wr_data  <= wdata_d;
      rsp_valid    <= valid_d;
      rsp_rdata    <= rdata_d;
      rsp_status   <= status_d;
      rsp_attempts <= attempts_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    mask_d     = mask_q;
    limit_d    = limit_q;
    att_d      = att_q;
    gap_d      = gap_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = csr_addr;
    wdata_d    = csr_wr_data;
    valid_d    = rsp_valid;
    rdata_d    = rsp_rdata;
    status_d   = rsp_status;
    attempts_d = rsp_attempts;
    // Saturate rather than wrap so an unlimited poll never reports a small count.
    att_inc    = (&att_q) ? att_q : att_q + TMO_W'(1);
    match      = (csr_rd_data & mask_q) == (exp_q & mask_q);

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          exp_d   = cmd_wdata;
          mask_d  = cmd_mask;
          limit_d = cmd_limit;
          att_d   = '0;
          case (cmd_op)
            OP_WRITE: begin
              state_d = S_WRITE;
              wr_en_d = 1'b1;
              addr_d  = cmd_addr;
              wdata_d = cmd_wdata;
            end
            OP_READ: begin
              state_d = S_READ;
              rd_en_d = 1'b1;
              addr_d  = cmd_addr;
            end
            OP_POLL: begin
              state_d = S_POLL_RD;
              rd_en_d = 1'b1;
              addr_d  = cmd_addr;
            end
            default: begin
              state_d    = S_RESP;
              valid_d    = 1'b1;
              rdata_d    = '0;
              status_d   = ST_ILLEGAL;
              attempts_d = '0;
            end
          endcase
        end
      end
      S_WRITE: begin
        state_d    = S_RESP;
        valid_d    = 1'b1;
        rdata_d    = '0;
        status_d   = ST_OK;
        attempts_d = '0;
      end
      S_READ: begin
        state_d    = S_RESP;
        valid_d    = 1'b1;
        rdata_d    = csr_rd_data;
        status_d   = ST_OK;
        attempts_d = TMO_W'(1);
      end
      S_POLL_RD: begin
        att_d      = att_inc;
        rdata_d    = csr_rd_data;
        attempts_d = att_inc;
        if (match) begin
          state_d  = S_RESP;
          valid_d  = 1'b1;
          status_d = ST_OK;
        end else if (limit_q != '0 && att_inc == limit_q) begin
          state_d  = S_RESP;
          valid_d  = 1'b1;
          status_d = ST_TIMEOUT;
        end else begin
          state_d = S_POLL_WAIT;
          gap_d   = '0;
        end
      end
      S_POLL_WAIT: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) begin
          state_d = S_POLL_RD;
          rd_en_d = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_initiator.sv
// tb/tb_csr_initiator.sv - self-checking bench with behavioural CSR responder and command model
module tb_csr_initiator;
  import csr_pkg::*;

  localparam int POLL_GAP = 4;
  localparam int TMO_W    = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [7:0]       cmd_addr = '0;
  logic [31:0]      cmd_wdata = '0;
  logic [31:0]      cmd_mask = '0;
  logic [TMO_W-1:0] cmd_limit = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_rdata;
  logic [1:0]       rsp_status;
  logic [TMO_W-1:0] rsp_attempts;
  logic             csr_wr_en, csr_rd_en;
  logic [7:0]       csr_addr;
  logic [31:0]      csr_wr_data;
  logic [31:0]      csr_rd_data;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural responder: CTRL/CFG writable, STATUS[0] mirrors CTRL[0], STATUS[1] rises after 5 armed reads.
  logic [31:0] ctrl = '0;
  logic [31:0] cfg = '0;
  logic        error_flag = 1'b0;
  logic        mem_start;
  logic [3:0]  mem_mode;
  int          cyc = 0, rd_cnt = 0, wr_cnt = 0, status_rd_cnt = 0, status_base = 0;
  bit          arm = 1'b0;
  int          rd_times[$];

  assign mem_start = ctrl[0];
  assign mem_mode  = ctrl[4:1];

  always #5 clk = ~clk;

  always_comb begin
    csr_rd_data = '0;
    case (csr_addr)
      CSR_CTRL:   csr_rd_data = ctrl;
      CSR_STATUS: csr_rd_data = {30'b0, arm && (status_rd_cnt - status_base >= 5), ctrl[0]};
      CSR_CFG:    csr_rd_data = cfg;
      CSR_ID:     csr_rd_data = CSR_ID_RESET;
      default:    csr_rd_data = '0;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (csr_wr_en && csr_rd_en) error_flag <= 1'b1;
    if (csr_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (csr_addr == CSR_CTRL) ctrl <= csr_wr_data;
      if (csr_addr == CSR_CFG)  cfg  <= csr_wr_data;
    end
    if (csr_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      rd_times.push_back(cyc);
      if (csr_addr == CSR_STATUS) status_rd_cnt <= status_rd_cnt + 1;
    end
  end

  csr_initiator #(.POLL_GAP(POLL_GAP), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask), .cmd_limit(cmd_limit),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .rsp_attempts(rsp_attempts),
    .csr_wr_en(csr_wr_en), .csr_rd_en(csr_rd_en), .csr_addr(csr_addr),
    .csr_wr_data(csr_wr_data), .csr_rd_data(csr_rd_data)
  );

  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [31:0] wd,
                       input logic [31:0] mk, input logic [TMO_W-1:0] lim);
    bit ok = 1'b0;
    @(negedge clk);
    cmd_op = op; cmd_addr = addr; cmd_wdata = wd; cmd_mask = mk; cmd_limit = lim;
    cmd_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 cmd_valid = 1'b0;
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL cmd_accept: cmd_ready never seen, want 1"); end
  endtask

  task automatic get_rsp(input int delay, output logic [1:0] st, output logic [31:0] rd,
                         output logic [TMO_W-1:0] at);
    bit seen = 1'b0;
    rsp_ready = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1'b1; break; end
    end
    repeat (delay) @(negedge clk);
    st = rsp_status; rd = rsp_rdata; at = rsp_attempts;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_cmp++;
    if (!seen) begin n_fail++; $display("FAIL rsp_timeout: rsp_valid never seen, want 1"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
    n_cmp++; if (rsp_status !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_status got %b want 00", rsp_status); end
    n_cmp++; if (rsp_attempts !== '0) begin n_fail++; $display("FAIL reset_rsp_attempts got %0d want 0", rsp_attempts); end
    n_cmp++; if ({csr_wr_en, csr_rd_en} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes got %b want 00", {csr_wr_en, csr_rd_en}); end
    n_cmp++; if (csr_addr !== 8'h0 || csr_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_csr_bus got %h/%h want 00/0", csr_addr, csr_wr_data); end
  endtask

  task automatic test_write();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    int w0 = wr_cnt;
    issue(OP_WRITE, CSR_CTRL, 32'h0000_001F, '0, '0);
    @(negedge clk);
    n_cmp++; if (csr_wr_en !== 1'b1 || csr_addr !== CSR_CTRL || csr_wr_data !== 32'h1F) begin n_fail++; $display("FAIL wr_strobe_k1 got en=%b addr=%h data=%h want 1/00/1f", csr_wr_en, csr_addr, csr_wr_data); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rsp_early got %b want 0", rsp_valid); end
    @(negedge clk);
    n_cmp++; if (csr_wr_en !== 1'b0 || rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_k2 got en=%b valid=%b want 0/1", csr_wr_en, rsp_valid); end
    n_cmp++; if (csr_wr_data !== 32'h1F) begin n_fail++; $display("FAIL wr_data_hold got %h want 1f", csr_wr_data); end
    get_rsp(0, st, rd, at);
    n_cmp++; if (st !== ST_OK || rd !== 32'h0 || at !== '0) begin n_fail++; $display("FAIL wr_rsp got %b/%h/%0d want 00/0/0", st, rd, at); end
    n_cmp++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL wr_pulses got %0d want 1", wr_cnt - w0); end
    n_cmp++; if (mem_start !== 1'b1 || mem_mode !== 4'hF) begin n_fail++; $display("FAIL wr_mem got start=%b mode=%h want 1/f", mem_start, mem_mode); end
  endtask

  task automatic test_read_id();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    int r0 = rd_cnt;
    issue(OP_READ, CSR_ID, '0, '0, '0);
    @(negedge clk);
    n_cmp++; if (csr_rd_en !== 1'b1 || csr_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd_strobe got rd=%b wr=%b want 1/0", csr_rd_en, csr_wr_en); end
    get_rsp(0, st, rd, at);
    n_cmp++; if (st !== ST_OK || rd !== 32'h1234_ABCD || at !== TMO_W'(1)) begin n_fail++; $display("FAIL rd_rsp got %b/%h/%0d want 00/1234abcd/1", st, rd, at); end
    n_cmp++; if (rd_cnt - r0 !== 1) begin n_fail++; $display("FAIL rd_pulses got %0d want 1", rd_cnt - r0); end
  endtask

  task automatic test_poll_ok();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    issue(OP_WRITE, CSR_CTRL, 32'h1, '0, '0);
    get_rsp(0, st, rd, at);
    issue(OP_POLL, CSR_STATUS, 32'h1, 32'h1, TMO_W'(8));
    get_rsp(1, st, rd, at);
    n_cmp++; if (st !== ST_OK || rd[0] !== 1'b1) begin n_fail++; $display("FAIL poll_ok got %b rd0=%b want 00/1", st, rd[0]); end
    n_cmp++; if (at < TMO_W'(1) || at > TMO_W'(2)) begin n_fail++; $display("FAIL poll_ok_att got %0d want 1..2", at); end
  endtask

  task automatic test_poll_timeout();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    int base;
    issue(OP_WRITE, CSR_CTRL, 32'h0, '0, '0);
    get_rsp(0, st, rd, at);
    base = rd_times.size();
    issue(OP_POLL, CSR_STATUS, 32'h1, 32'h1, TMO_W'(3));
    get_rsp(0, st, rd, at);
    n_cmp++; if (st !== ST_TIMEOUT || rd !== 32'h0 || at !== TMO_W'(3)) begin n_fail++; $display("FAIL poll_tmo got %b/%h/%0d want 01/0/3", st, rd, at); end
    n_cmp++; if (rd_times.size() - base !== 3) begin n_fail++; $display("FAIL poll_tmo_pulses got %0d want 3", rd_times.size() - base); end
    for (int i = 0; i < 2; i++) begin
      if (base + i + 1 < rd_times.size()) begin
        n_cmp++;
        if (rd_times[base+i+1] - rd_times[base+i] !== POLL_GAP + 1) begin n_fail++; $display("FAIL poll_spacing%0d got %0d want %0d", i, rd_times[base+i+1] - rd_times[base+i], POLL_GAP + 1); end
      end
    end
  endtask

  task automatic test_poll_unlimited();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    status_base = status_rd_cnt;
    arm = 1'b1;
    issue(OP_POLL, CSR_STATUS, 32'h2, 32'h2, '0);
    get_rsp(0, st, rd, at);
    arm = 1'b0;
    n_cmp++; if (st !== ST_OK || rd[1] !== 1'b1 || at !== TMO_W'(6)) begin n_fail++; $display("FAIL poll_unlim got %b rd1=%b att=%0d want 00/1/6", st, rd[1], at); end
  endtask

  task automatic test_illegal();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    int w0 = wr_cnt, r0 = rd_cnt;
    rsp_ready = 1'b0;
    issue(OP_RSVD, 8'h08, 32'hDEAD_BEEF, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_status !== ST_ILLEGAL || cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL illegal_hold%0d got v=%b st=%b rdy=%b want 1/10/0", i, rsp_valid, rsp_status, cmd_ready);
      end
    end
    get_rsp(0, st, rd, at);
    n_cmp++; if (st !== ST_ILLEGAL || rd !== 32'h0 || at !== '0) begin n_fail++; $display("FAIL illegal_rsp got %b/%h/%0d want 10/0/0", st, rd, at); end
    n_cmp++; if (wr_cnt != w0 || rd_cnt != r0) begin n_fail++; $display("FAIL illegal_strobes got wr=%0d rd=%0d want 0/0", wr_cnt - w0, rd_cnt - r0); end
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready_after got %b want 1", cmd_ready); end
  endtask

  task automatic test_rst_abort();
    int r0;
    bit seen = 1'b0, bad = 1'b0;
    issue(OP_POLL, CSR_STATUS, 32'h1, 32'h1, '0);
    r0 = rd_cnt;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (rd_cnt > r0) begin seen = 1'b1; break; end
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL abort_first_read: no read pulse, want 1"); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if ({csr_wr_en, csr_rd_en, rsp_valid} !== 3'b000) begin n_fail++; $display("FAIL abort_outputs got wr/rd/v=%b want 000", {csr_wr_en, csr_rd_en, rsp_valid}); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", cmd_ready); end
    r0 = rd_cnt;
    rsp_ready = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || csr_rd_en || csr_wr_en) bad = 1'b1;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (bad || rd_cnt != r0) begin n_fail++; $display("FAIL abort_quiet got activity=%b reads=%0d want 0/0", bad, rd_cnt - r0); end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a, input logic [31:0] m_ctrl, input logic [31:0] m_cfg);
    case (a)
      CSR_CTRL:   return m_ctrl;
      CSR_STATUS: return {31'b0, m_ctrl[0]};
      CSR_CFG:    return m_cfg;
      CSR_ID:     return CSR_ID_RESET;
      default:    return 32'h0;
    endcase
  endfunction

  task automatic test_random();
    logic [1:0] st; logic [31:0] rd; logic [TMO_W-1:0] at;
    logic [31:0] m_ctrl = '0, m_cfg = '0;
    logic [7:0] addrs [6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h24};
    logic [1:0] e_st; logic [31:0] e_rd; logic [TMO_W-1:0] e_at;
    issue(OP_WRITE, CSR_CTRL, 32'h0, '0, '0); get_rsp(0, st, rd, at);
    issue(OP_WRITE, CSR_CFG, 32'h0, '0, '0);  get_rsp(0, st, rd, at);
    for (int i = 0; i < 40; i++) begin
      logic [1:0] op = 2'($urandom_range(0, 3));
      logic [7:0] a = addrs[$urandom_range(0, 5)];
      logic [31:0] wd = $urandom;
      logic [31:0] mk = $urandom;
      logic [TMO_W-1:0] lim = TMO_W'($urandom_range(1, 4));
      logic [31:0] cur = model_read(a, m_ctrl, m_cfg);
      if (op == OP_POLL && $urandom_range(0, 1) == 1) wd = cur;
      case (op)
        OP_WRITE: begin
          e_st = ST_OK; e_rd = '0; e_at = '0;
          if (a == CSR_CTRL) m_ctrl = wd;
          if (a == CSR_CFG)  m_cfg  = wd;
        end
        OP_READ: begin e_st = ST_OK; e_rd = cur; e_at = TMO_W'(1); end
        OP_POLL: begin
          e_rd = cur;
          if ((cur & mk) == (wd & mk)) begin e_st = ST_OK; e_at = TMO_W'(1); end
          else begin e_st = ST_TIMEOUT; e_at = lim; end
        end
        default: begin e_st = ST_ILLEGAL; e_rd = '0; e_at = '0; end
      endcase
      issue(op, a, wd, mk, lim);
      get_rsp($urandom_range(0, 3), st, rd, at);
      n_cmp++;
      if (st !== e_st || rd !== e_rd || at !== e_at) begin
        n_fail++; $display("FAIL rand%0d op=%0d addr=%h got %b/%h/%0d want %b/%h/%0d", i, op, a, st, rd, at, e_st, e_rd, e_at);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_id();
    test_poll_ok();
    test_poll_timeout();
    test_poll_unlimited();
    test_illegal();
    test_rst_abort();
    test_random();
    n_cmp++; if (error_flag !== 1'b0) begin n_fail++; $display("FAIL error_flag got %b want 0", error_flag); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
